// File: rtl/priority_demux.sv
// rtl/priority_demux.sv - registered one-to-many distributor, lowest enabled destination wins
//
// Optional feature: define PRIORITY_DEMUX_CNT_EN to add the xfer_cnt delivered-beat counter.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   din       in   [WIDTH]  input data
//   din_vld   in   input beat valid
//   din_rdy   out  input beat accepted when din_vld & din_rdy
//   dest_en   in   [CNT]    destination enable mask, bit 0 highest priority
//   dout      out  [WIDTH]  shared output data, held while the entry is full
//   dout_vld  out  [CNT]    one-hot per-destination valid
//   dout_rdy  in   [CNT]    per-destination ready
//   xfer_cnt  out  [16]     saturating delivered-beat count (PRIORITY_DEMUX_CNT_EN only)

module priority_demux #(
  parameter int WIDTH = 32,
  parameter int CNT   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic             din_rdy,
  input  logic [CNT-1:0]   dest_en,
  output logic [WIDTH-1:0] dout,
  output logic [CNT-1:0]   dout_vld,
  input  logic [CNT-1:0]   dout_rdy
`ifdef PRIORITY_DEMUX_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  logic             full;
  logic [CNT-1:0]   sel_q;
  logic [CNT-1:0]   sel_nxt;
  logic [WIDTH-1:0] dout_q;
  logic             drain;
  logic             accept;

  // Two's-complement trick isolates the lowest set bit of the enable mask.
  assign sel_nxt = dest_en & (-dest_en);

  // Only the ready of the destination the held beat is tagged for counts.
  assign drain   = full & (|(sel_q & dout_rdy));

  // Ready passes through from the selected destination so a draining entry
  // can be refilled in the same cycle; no destination means the beat waits.
  assign din_rdy = (|dest_en) & (~full | drain);
  assign accept  = din_vld & din_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 1'b0;
      sel_q  <= '0;
      dout_q <= '0;
    end else if (accept) begin
      full   <= 1'b1;
      sel_q  <= sel_nxt;
      dout_q <= din;
    end else if (drain) begin
      full   <= 1'b0;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = sel_q & {CNT{full}};

`ifdef PRIORITY_DEMUX_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (drain && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_priority_demux.sv
// tb/tb_priority_demux.sv - self-checking bench for priority_demux (WIDTH=8, CNT=4)

module tb_priority_demux;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_vld;
  logic       din_rdy;
  logic [3:0] dest_en;
  logic [7:0] dout;
  logic [3:0] dout_vld;
  logic [3:0] dout_rdy;
`ifdef PRIORITY_DEMUX_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  priority_demux #(.WIDTH(8), .CNT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .dest_en  (dest_en),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
`ifdef PRIORITY_DEMUX_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Beat-level reference: beats in flight, each with the index of its destination.
  typedef struct {
    logic [7:0] data;
    int         dest;
  } beat_t;

  beat_t model_q[$];
  int    model_cnt = 0;

  function automatic int lowest_dest(input logic [3:0] en);
    for (int i = 0; i < 4; i++) begin
      if (en[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic model_rdy();
    if (en_none()) return 1'b0;
    if (model_q.size() == 0) return 1'b1;
    return dout_rdy[model_q[0].dest];
  endfunction

  function automatic logic en_none();
    return dest_en == 4'b0000;
  endfunction

  function automatic logic [3:0] model_vld();
    logic [3:0] v;
    v = 4'b0000;
    if (model_q.size() != 0) v[model_q[0].dest] = 1'b1;
    return v;
  endfunction

  // Advance one clock and update the reference from the inputs seen at the edge.
  task automatic tick();
    logic  acc;
    logic  drn;
    beat_t b;
    acc = din_vld && model_rdy();
    drn = (model_q.size() != 0) && dout_rdy[model_q[0].dest];
    b.data = din;
    b.dest = lowest_dest(dest_en);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_cnt = 0;
    end else begin
      if (drn) begin
        void'(model_q.pop_front());
        if (model_cnt < 65535) model_cnt++;
      end
      if (acc) model_q.push_back(b);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    dest_en = 4'b0110;
    #1;
    n_tests++;
    if (dout_vld !== 4'b0000) begin
      n_fail++; $display("FAIL reset_vld: got %b expected %b", dout_vld, 4'b0000);
    end
    n_tests++;
    if (dout !== 8'h00) begin
      n_fail++; $display("FAIL reset_dout: got %h expected %h", dout, 8'h00);
    end
    n_tests++;
    if (din_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_rdy: got %b expected %b", din_rdy, 1'b1);
    end
`ifdef PRIORITY_DEMUX_CNT_EN
    n_tests++;
    if (xfer_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", xfer_cnt);
    end
`endif
  endtask

  task automatic test_basic();
    dest_en  = 4'b1100;
    dout_rdy = 4'b1111;
    din      = 8'hA5;
    din_vld  = 1'b1;
    #1;
    n_tests++;
    if (din_rdy !== 1'b1) begin
      n_fail++; $display("FAIL basic_rdy: got %b expected 1", din_rdy);
    end
    tick();
    din_vld = 1'b0;
    #1;
    n_tests++;
    if (dout !== 8'hA5 || dout_vld !== 4'b0100) begin
      n_fail++; $display("FAIL basic_out: got %h/%b expected a5/0100", dout, dout_vld);
    end
    tick();
    n_tests++;
    if (dout_vld !== 4'b0000) begin
      n_fail++; $display("FAIL basic_drained: got %b expected 0000", dout_vld);
    end
  endtask

  task automatic test_stall();
    dest_en  = 4'b0010;
    dout_rdy = 4'b0000;
    din      = 8'h11;
    din_vld  = 1'b1;
    tick();
    din     = 8'h22;
    dest_en = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (dout_vld !== 4'b0010 || dout !== 8'h11 || din_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: got vld=%b dout=%h rdy=%b expected 0010/11/0", dout_vld, dout, din_rdy);
      end
      tick();
    end
    dout_rdy = 4'b0010;
    #1;
    n_tests++;
    if (din_rdy !== 1'b1) begin
      n_fail++; $display("FAIL stall_release_rdy: got %b expected 1", din_rdy);
    end
    tick();
    din_vld  = 1'b0;
    dout_rdy = 4'b0000;
    #1;
    n_tests++;
    if (dout_vld !== 4'b0001 || dout !== 8'h22) begin
      n_fail++; $display("FAIL stall_next: got %b/%h expected 0001/22", dout_vld, dout);
    end
    dout_rdy = 4'b1111;
    tick();
  endtask

  task automatic test_back_to_back();
    dest_en  = 4'b1000;
    dout_rdy = 4'b1000;
    din_vld  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      din = 8'(i);
      #1;
      n_tests++;
      if (din_rdy !== 1'b1) begin
        n_fail++; $display("FAIL b2b_rdy: beat %0d got %b expected 1", i, din_rdy);
      end
      if (i > 1) begin
        n_tests++;
        if (dout !== 8'(i - 1) || dout_vld !== 4'b1000) begin
          n_fail++; $display("FAIL b2b_out: got %h/%b expected %h/1000", dout, dout_vld, 8'(i - 1));
        end
      end
      tick();
    end
    din_vld = 1'b0;
    #1;
    n_tests++;
    if (dout !== 8'h08 || dout_vld !== 4'b1000) begin
      n_fail++; $display("FAIL b2b_last: got %h/%b expected 08/1000", dout, dout_vld);
    end
    tick();
    n_tests++;
    if (dout_vld !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_empty: got %b expected 0000", dout_vld);
    end
  endtask

  task automatic test_no_dest();
    dest_en  = 4'b0000;
    dout_rdy = 4'b1111;
    din      = 8'h5A;
    din_vld  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (din_rdy !== 1'b0 || dout_vld !== 4'b0000) begin
        n_fail++; $display("FAIL nodest_idle: got rdy=%b vld=%b expected 0/0000", din_rdy, dout_vld);
      end
      tick();
    end
    dest_en = 4'b0001;
    #1;
    n_tests++;
    if (din_rdy !== 1'b1) begin
      n_fail++; $display("FAIL nodest_enable: got %b expected 1", din_rdy);
    end
    tick();
    din_vld = 1'b0;
    #1;
    n_tests++;
    if (dout_vld !== 4'b0001 || dout !== 8'h5A) begin
      n_fail++; $display("FAIL nodest_out: got %b/%h expected 0001/5a", dout_vld, dout);
    end
    tick();
  endtask

  task automatic test_wrong_ready();
    dest_en  = 4'b0100;
    dout_rdy = 4'b0000;
    din      = 8'h77;
    din_vld  = 1'b1;
    tick();
    dout_rdy = 4'b1011;
    din      = 8'h88;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (dout_vld !== 4'b0100 || din_rdy !== 1'b0 || dout !== 8'h77) begin
        n_fail++;
        $display("FAIL wrong_rdy: got vld=%b rdy=%b dout=%h expected 0100/0/77", dout_vld, din_rdy, dout);
      end
      tick();
    end
    din_vld  = 1'b0;
    dout_rdy = 4'b1111;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    dest_en  = 4'b0001;
    dout_rdy = 4'b0000;
    din      = 8'h99;
    din_vld  = 1'b1;
    tick();
    din_vld = 1'b0;
    #1;
    n_tests++;
    if (dout_vld !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_held: got %b expected 0001", dout_vld);
    end
    rst     = 1'b1;
    dout_rdy = 4'b1111;
    din_vld = 1'b1;
    tick();
    rst     = 1'b0;
    din_vld = 1'b0;
    #1;
    n_tests++;
    if (dout_vld !== 4'b0000 || dout !== 8'h00) begin
      n_fail++; $display("FAIL rstmid_clear: got %b/%h expected 0000/00", dout_vld, dout);
    end
  endtask

`ifdef PRIORITY_DEMUX_CNT_EN
  task automatic test_counter();
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    dest_en  = 4'b0001;
    dout_rdy = 4'b1111;
    din_vld  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    din_vld = 1'b0;
    tick();
    n_tests++;
    if (xfer_cnt !== 16'd3) begin
      n_fail++; $display("FAIL cnt_three: got %0d expected 3", xfer_cnt);
    end
    din_vld = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    din_vld = 1'b0;
    tick();
    n_tests++;
    if (xfer_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL cnt_saturate: got %h expected ffff", xfer_cnt);
    end
    n_tests++;
    if (xfer_cnt !== 16'(model_cnt)) begin
      n_fail++; $display("FAIL cnt_model: got %0d expected %0d", xfer_cnt, model_cnt);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      dest_en  = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      din      = 8'($urandom);
      din_vld  = ($urandom_range(0, 3) != 0);
      dout_rdy = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
      #1;
      n_tests++;
      if (din_rdy !== model_rdy()) begin
        n_fail++; $display("FAIL rand_rdy: cycle %0d got %b expected %b", i, din_rdy, model_rdy());
      end
      n_tests++;
      if (dout_vld !== model_vld()) begin
        n_fail++; $display("FAIL rand_vld: cycle %0d got %b expected %b", i, dout_vld, model_vld());
      end
      if (model_q.size() != 0) begin
        n_tests++;
        if (dout !== model_q[0].data) begin
          n_fail++; $display("FAIL rand_dout: cycle %0d got %h expected %h", i, dout, model_q[0].data);
        end
      end
      tick();
    end
    din_vld = 1'b0;
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    din      = 8'h00;
    din_vld  = 1'b0;
    dest_en  = 4'b0000;
    dout_rdy = 4'b0000;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_no_dest();
    test_wrong_ready();
    test_reset_mid();
`ifdef PRIORITY_DEMUX_CNT_EN
    test_counter();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_demux.md
# priority_demux

Registered one-to-many distributor, the counterpart of `priority_mux`: one valid/ready input stream is steered to exactly one of `CNT` destinations. For each beat, the destination is the highest-priority enabled one, and bit 0 has the highest priority. A single-entry output register holds the beat until the selected destination accepts it, and full throughput is kept through ready pass-through. Used in spcom fan-out paths, such as request dispatch to parallel engines.

## Interface
- `WIDTH`, default 32: data width.
- `CNT`, default 5: number of destinations. Must be ≥ 1.
- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `din`, in, `WIDTH`: input data.
- `din_vld`, in, 1: input beat valid.
- `din_rdy`, out, 1: input beat accepted when `din_vld & din_rdy`.
- `dest_en`, in, `CNT`: destination enable mask. The lowest set bit wins.
- `dout`, out, `WIDTH`: shared output data bus, held while the entry is full.
- `dout_vld`, out, `CNT`: one-hot per-destination valid.
- `dout_rdy`, in, `CNT`: per-destination ready.
- `xfer_cnt`, out, 16: delivered-beat counter. Present only with `PRIORITY_DEMUX_CNT_EN`.

## Operation
- State:
  - `full` flag.
  - `sel_q[CNT]`, a one-hot tag.
  - `dout` register.
- `sel_nxt` = isolate lowest set bit of `dest_en` (`dest_en & -dest_en`).
- `drain` = `full & |(sel_q & dout_rdy)`.
  - `dout_rdy` bits not matching `sel_q` are ignored.
- `din_rdy` = `|dest_en & (~full | drain)`. This is combinational from `dest_en`, `dout_rdy` and state.
  - `dest_en == 0` means `din_rdy = 0`. The beat waits upstream and is never dropped.
- `accept` = `din_vld & din_rdy`. On accept:
  - `dout <= din`
  - `sel_q <= sel_nxt`
  - `full <= 1`
- Drain without accept: `full <= 0`. `sel_q` and `dout` keep their values; they are don't-care for verification.
- Drain and accept in the same cycle: the new beat is loaded. `full` stays 1 and the tag switches to `sel_nxt`.
- The destination is frozen at accept. Changes to `dest_en` while full do not retarget the held beat.
- `dout_vld` = `sel_q & {CNT{full}}`. At most one bit is set at any time.
- Beats are delivered in input order. There is no reordering and no duplication.

## Timing
- Reset values:
  - `full = 0`, `sel_q = 0`, `dout = 0`.
  - `dout_vld = 0`, so no output is ever valid during or right after reset.
  - `din_rdy = |dest_en` the cycle after reset.
  - `xfer_cnt = 0`.
- Latency: a beat accepted at edge N is presented on `dout` / `dout_vld` from cycle N+1.
- Throughput: 1 beat/cycle when the selected destination holds `dout_rdy` high.
- Stall: `dout` and `dout_vld` stay stable while `full & ~drain`.
- Reset mid-operation: the held beat is discarded. `rst` overrides accept and drain in the same cycle.
- `CNT == 1`: the block degenerates to a one-entry pipeline register gated by `dest_en[0]`.

## Configuration
- `PRIORITY_DEMUX_CNT_EN` defined:
  - `xfer_cnt` increments by 1 on every drain and saturates at 16'hFFFF. It does not wrap.
  - It is cleared only by `rst`.
- Not defined: the `xfer_cnt` port and counter logic are absent. Datapath behaviour is identical.

## Test plan
(`WIDTH=8`, `CNT=4`)
1. Basic steering.
   - Stimulus: `dest_en=4'b1100`, all `dout_rdy=1`, send `8'hA5`.
   - Required: next cycle `dout=8'hA5`, `dout_vld=4'b0100`; it drains that cycle and `dout_vld=0` the cycle after.
2. Stall and freeze.
   - Stimulus: `dest_en=4'b0010`, `dout_rdy=0`, send `8'h11`, then change `dest_en` to `4'b0001`.
   - Required: `dout_vld` stays `4'b0010` with `dout=8'h11`. `din_rdy=0` until `dout_rdy[1]=1`, then the next beat goes to `4'b0001`.
3. Back-to-back.
   - Stimulus: `dest_en=4'b1000`, `dout_rdy[3]=1`, stream `8'h01`..`8'h08` with continuous valid.
   - Required: `din_rdy` stays 1 throughout. The 8 beats appear on consecutive cycles in order on `dout_vld=4'b1000`.
4. No destination.
   - Stimulus: `dest_en=0`, `din_vld=1`.
   - Required: `din_rdy=0` and `dout_vld=0` indefinitely. Setting `dest_en=4'b0001` gives accept in that cycle.
5. Wrong-destination ready.
   - Stimulus: beat held for `4'b0100`, `dout_rdy=4'b1011`.
   - Required: no drain and `din_rdy=0`.
6. Reset mid-flight and counter.
   - Stimulus: hold a beat, assert `rst` for 1 cycle.
   - Required: `dout_vld=0` next cycle.
   - With `PRIORITY_DEMUX_CNT_EN`, 3 drains give `xfer_cnt=3`. Preloading via 65540 drains gives saturation at 16'hFFFF.
